// File: rtl/adc083000_snap_capture.sv
// Triggered snapshot capture of 64-bit ADC sample words into a simple-dual-port BRAM.
// Latency: one cycle from a word sitting in the input register to its bram_we (zero trigger delay).
// No backpressure: the ADC stream runs every cycle and the BRAM write port always accepts.
module adc083000_snap_capture #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 64,
    parameter int DELAY_W = 16
) (
    input  logic              adc_clk,
    input  logic              ctrl_reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [3:0]        adc_sync,
    input  logic [3:0]        adc_outofrange,
    input  logic              ext_trig,
    input  logic              ctrl_arm,
    input  logic [1:0]        ctrl_trig_src,
    input  logic [DELAY_W-1:0] ctrl_delay,
    input  logic [ADDR_W-1:0] ctrl_num_words,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic              status_busy,
    output logic              status_done,
    output logic              status_ovr,
    output logic [ADDR_W-1:0] status_count
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE} state_t;

    state_t               state;
    logic [DATA_W-1:0]    r1_data;
    logic [3:0]           r1_sync;
    logic [3:0]           r1_oor;
    logic                 r1_ext;
    logic                 arm_q;
    logic [1:0]           src_l;
    logic [DELAY_W-1:0]   delay_l;
    logic [ADDR_W-1:0]    num_l;
    logic [DELAY_W-1:0]   dly_cnt;
    logic [ADDR_W-1:0]    wr_idx;
    logic                 fin;

    logic                 arm_edge;
    logic                 trig;
    logic                 store;
    logic [ADDR_W-1:0]    last_idx;

    // A count of 0 wraps to all-ones here, which is exactly the 2**ADDR_W-word case.
    assign last_idx = num_l - 1'b1;
    assign arm_edge = ctrl_arm & ~arm_q;

    // Trigger qualification from the registered inputs; sources 2/3 fire on the first ARMED cycle.
    always_comb begin
        trig = 1'b1;
        if (src_l == 2'd0)
            trig = |r1_sync;
        else if (src_l == 2'd1)
            trig = r1_ext;
    end

    // Store the word in r1 this cycle: on a zero-delay trigger, at the end of the delay, or
    // throughout CAPTURE until the final word has been issued.
    always_comb begin
        store = 1'b0;
        case (state)
            ARMED:   store = trig && (delay_l == '0);
            DELAY:   store = (dly_cnt == DELAY_W'(1));
            CAPTURE: store = !fin;
            default: store = 1'b0;
        endcase
    end

    // Input register stage; all trigger decisions and stored data come from here.
    always_ff @(posedge adc_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r1_data <= '0;
            r1_sync <= '0;
            r1_oor  <= '0;
            r1_ext  <= 1'b0;
        end else begin
            r1_data <= adc_data;
            r1_sync <= adc_sync;
            r1_oor  <= adc_outofrange;
            r1_ext  <= ext_trig;
        end
    end

    // Capture FSM with registered BRAM write port and status outputs.
    always_ff @(posedge adc_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state        <= IDLE;
            arm_q        <= 1'b0;
            src_l        <= '0;
            delay_l      <= '0;
            num_l        <= '0;
            dly_cnt      <= '0;
            wr_idx       <= '0;
            fin          <= 1'b0;
            bram_addr    <= '0;
            bram_data    <= '0;
            bram_we      <= 1'b0;
            status_busy  <= 1'b0;
            status_done  <= 1'b0;
            status_ovr   <= 1'b0;
            status_count <= '0;
        end else begin
            arm_q   <= ctrl_arm;
            bram_we <= 1'b0;
            if (store) begin
                bram_we      <= 1'b1;
                bram_addr    <= wr_idx;
                bram_data    <= r1_data;
                wr_idx       <= wr_idx + 1'b1;
                status_count <= status_count + 1'b1;
                status_ovr   <= status_ovr | (|r1_oor);
                fin          <= (wr_idx == last_idx);
            end
            case (state)
                IDLE, DONE: begin
                    if (arm_edge) begin
                        src_l        <= ctrl_trig_src;
                        delay_l      <= ctrl_delay;
                        num_l        <= ctrl_num_words;
                        wr_idx       <= '0;
                        fin          <= 1'b0;
                        status_done  <= 1'b0;
                        status_ovr   <= 1'b0;
                        status_count <= '0;
                        status_busy  <= 1'b1;
                        state        <= ARMED;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        if (delay_l == '0) begin
                            state <= CAPTURE;
                        end else begin
                            dly_cnt <= delay_l;
                            state   <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    dly_cnt <= dly_cnt - 1'b1;
                    if (dly_cnt == DELAY_W'(1))
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    // fin marks that the last write is on the port this cycle.
                    if (fin) begin
                        status_busy <= 1'b0;
                        status_done <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc083000_snap_capture.sv
// Directed bench for the snapshot capture block with a small BRAM (ADDR_W=4).
// Drives inputs #1 after the rising edge and samples outputs there or on the falling edge.
// Every write seen on the BRAM port is logged and compared against hand-derived values.
module tb_adc083000_snap_capture;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 64;
    localparam int DELAY_W = 16;
    localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              ctrl_reset = 1'b1;
    logic [DATA_W-1:0] adc_data = '0;
    logic [3:0]        adc_sync = '0;
    logic [3:0]        adc_outofrange = '0;
    logic              ext_trig = 1'b0;
    logic              ctrl_arm = 1'b0;
    logic [1:0]        ctrl_trig_src = '0;
    logic [DELAY_W-1:0] ctrl_delay = '0;
    logic [ADDR_W-1:0] ctrl_num_words = '0;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic              status_busy;
    logic              status_done;
    logic              status_ovr;
    logic [ADDR_W-1:0] status_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          wr_n = 0;
    logic [63:0] wa [128];
    logic [63:0] wd [128];
    int          wc [128];

    adc083000_snap_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DELAY_W(DELAY_W)) dut (
        .adc_clk        (clk),
        .ctrl_reset     (ctrl_reset),
        .adc_data       (adc_data),
        .adc_sync       (adc_sync),
        .adc_outofrange (adc_outofrange),
        .ext_trig       (ext_trig),
        .ctrl_arm       (ctrl_arm),
        .ctrl_trig_src  (ctrl_trig_src),
        .ctrl_delay     (ctrl_delay),
        .ctrl_num_words (ctrl_num_words),
        .bram_addr      (bram_addr),
        .bram_data      (bram_data),
        .bram_we        (bram_we),
        .status_busy    (status_busy),
        .status_done    (status_done),
        .status_ovr     (status_ovr),
        .status_count   (status_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every BRAM write with the cycle it appeared in.
    always @(negedge clk) begin
        if (bram_we === 1'b1 && wr_n < 128) begin
            wa[wr_n] <= 64'(bram_addr);
            wd[wr_n] <= bram_data;
            wc[wr_n] <= cyc;
            wr_n     <= wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word for one cycle; flags are raised only on the words that match.
    task automatic word(input logic [63:0] d, input logic [63:0] sync_at,
                        input logic [63:0] ext_at, input logic [63:0] oor_a,
                        input logic [63:0] oor_b);
        adc_data       = d;
        adc_sync       = (d == sync_at) ? 4'b0100 : 4'b0000;
        ext_trig       = (d == ext_at);
        adc_outofrange = (d == oor_a || d == oor_b) ? 4'b0001 : 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ctrl_arm = 1'b0;
        word(64'hDEAD, NONE, NONE, NONE, NONE);
    endtask

    // Compare the writes logged since index base against a ramp starting at d0 in cycle c0.
    task automatic check_writes(input string tag, input int base, input int n,
                                input logic [63:0] d0, input int c0);
        check($sformatf("%s_nwr", tag), 64'(wr_n - base), 64'(n));
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_addr%0d", tag, k), wa[base+k], 64'(k));
            check($sformatf("%s_data%0d", tag, k), wd[base+k], d0 + 64'(k));
            check($sformatf("%s_cyc%0d", tag, k), 64'(wc[base+k]), 64'(c0 + k));
        end
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done,
                                input logic ovr, input logic [ADDR_W-1:0] cnt);
        check($sformatf("%s_busy", tag), 64'(status_busy), 64'(busy));
        check($sformatf("%s_done", tag), 64'(status_done), 64'(done));
        check($sformatf("%s_ovr", tag), 64'(status_ovr), 64'(ovr));
        check($sformatf("%s_count", tag), 64'(status_count), 64'(cnt));
        check($sformatf("%s_we", tag), 64'(bram_we), 64'b0);
    endtask

    initial begin
        int a;
        int base;
        bit seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_status("rst", 1'b0, 1'b0, 1'b0, '0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_data", bram_data, 64'd0);
        ctrl_reset = 1'b0;
        idle();

        // Immediate trigger, N=4, with an arm edge during CAPTURE that must be ignored
        ctrl_trig_src = 2'd2; ctrl_delay = 16'd0; ctrl_num_words = 4'd4;
        base = wr_n; a = cyc; ctrl_arm = 1'b1;
        word(64'd0, NONE, NONE, NONE, NONE);
        check("imm_armed_busy", 64'(status_busy), 64'b1);
        check("imm_armed_we", 64'(bram_we), 64'b0);
        for (int i = 1; i < 10; i++) begin
            if (i == 2) ctrl_arm = 1'b0;
            if (i == 3) ctrl_arm = 1'b1;
            word(64'(i), NONE, NONE, NONE, NONE);
        end
        check_writes("imm", base, 4, 64'd0, a + 2);
        check_status("imm_end", 1'b0, 1'b1, 1'b0, 4'd4);
        check("imm_addr_hold", 64'(bram_addr), 64'd3);

        // Sync trigger on 0x55 with delay 3, N=2; ctrl changes after latching are ignored
        idle();
        ctrl_trig_src = 2'd0; ctrl_delay = 16'd3; ctrl_num_words = 4'd2;
        base = wr_n; a = cyc; ctrl_arm = 1'b1;
        for (int i = 0; i < 16; i++) begin
            word(64'h50 + 64'(i), 64'h55, NONE, NONE, NONE);
            ctrl_delay = 16'd0; ctrl_num_words = 4'd7; ctrl_trig_src = 2'd2;
        end
        check_writes("sync", base, 2, 64'h58, a + 10);
        check_status("sync_end", 1'b0, 1'b1, 1'b0, 4'd2);

        // External trigger, N=8, out-of-range on stored word 5 only
        idle();
        ctrl_trig_src = 2'd1; ctrl_delay = 16'd0; ctrl_num_words = 4'd8;
        base = wr_n; a = cyc; ctrl_arm = 1'b1;
        for (int i = 0; i < 20; i++)
            word(64'h0C + 64'(i), 64'h0D, 64'h10, 64'h15, NONE);
        check_writes("ext", base, 8, 64'h10, a + 6);
        check_status("ext_end", 1'b0, 1'b1, 1'b1, 4'd8);

        // Re-arm: out-of-range only on words outside the stored window
        idle();
        base = wr_n; a = cyc; ctrl_arm = 1'b1;
        for (int i = 0; i < 20; i++)
            word(64'h0C + 64'(i), NONE, 64'h10, 64'h0C, 64'h18);
        check_writes("clean", base, 8, 64'h10, a + 6);
        check_status("clean_end", 1'b0, 1'b1, 1'b0, 4'd8);

        // N=0 stores the full 16 words; arm held high gives no second capture
        idle();
        ctrl_trig_src = 2'd2; ctrl_delay = 16'd0; ctrl_num_words = 4'd0;
        base = wr_n; a = cyc; ctrl_arm = 1'b1;
        for (int i = 0; i < 40; i++)
            word(64'h100 + 64'(i), NONE, NONE, NONE, NONE);
        check_writes("full", base, 16, 64'h100, a + 2);
        check_status("full_end", 1'b0, 1'b1, 1'b0, 4'd0);
        check("full_addr_hold", 64'(bram_addr), 64'd15);

        // Reset in the middle of an N=8 capture, at the write of word 3
        idle();
        ctrl_num_words = 4'd8;
        ctrl_arm = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            word(64'h200 + 64'(i), NONE, NONE, NONE, NONE);
            seen = (bram_we === 1'b1 && bram_addr == 4'd3);
        end
        check("rstmid_reached_w3", 64'(seen), 64'b1);
        check("rstmid_w3_data", bram_data, 64'h203);
        ctrl_reset = 1'b1;
        #1;
        check_status("rstmid", 1'b0, 1'b0, 1'b0, '0);
        check("rstmid_addr", 64'(bram_addr), 64'd0);
        check("rstmid_data", bram_data, 64'd0);
        ctrl_arm = 1'b0;
        @(posedge clk);
        #1;
        ctrl_reset = 1'b0;
        base = wr_n;
        for (int i = 0; i < 4; i++) idle();
        check("rstmid_no_writes", 64'(wr_n - base), 64'd0);
        check("rstmid_idle_busy", 64'(status_busy), 64'b0);

        // Fresh arm after reset captures from address 0
        ctrl_num_words = 4'd2;
        base = wr_n; a = cyc; ctrl_arm = 1'b1;
        for (int i = 0; i < 8; i++)
            word(64'h300 + 64'(i), NONE, NONE, NONE, NONE);
        check_writes("rearm", base, 2, 64'h300, a + 2);
        check_status("rearm_end", 1'b0, 1'b1, 1'b0, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
